// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-organised data memory answering the load/store port over valid/ready.
// One request in flight; byte-strobed stores, full-word loads, misaligned/out-of-range flagged in resp_err.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic             commit;
    logic [31:0]      c_addr;
    logic             c_write;
    logic [31:0]      c_wdata;
    logic [3:0]       c_wstrb;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;
    logic             mem_we;

    // With no wait states the access commits on the acceptance edge, straight from the ports.
    always_comb begin
        if (state_q == IDLE) begin
            c_addr  = req_addr;
            c_write = req_write;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_addr  = addr_q;
            c_write = write_q;
            c_wdata = wdata_q;
            c_wstrb = wstrb_q;
        end
        c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_WIDTH] != '0);
        c_idx = c_addr[ADDR_WIDTH-1:2];
        commit = 1'b0;
        case (state_q)
            IDLE:    commit = req_valid && (WAIT_CYCLES == 0);
            WAIT:    commit = (cnt_q == 4'd0);
            default: commit = 1'b0;
        endcase
        mem_we = commit && c_write && !c_err && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == IDLE && req_valid) begin
            addr_d  = req_addr;
            write_d = req_write;
            wdata_d = req_wdata;
            wstrb_d = req_wstrb;
            cnt_d   = CNT_INIT;
        end
        if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_write) ? 32'd0 : mem[c_idx];
        end
        if (state_q == RESP && resp_ready) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Array deliberately has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && c_wstrb[i]) begin
                mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (one wait state plus a zero-wait instance).
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_wstrb;

    mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_write(b_req_write), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    localparam int W = 1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a 512-byte word array; a request is busy for W edges, then its response waits for resp_ready.
    logic [31:0] mm [128];
    logic        m_busy, m_valid, m_err;
    int          m_left;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_write;
    logic [3:0]  m_wstrb;

    function automatic bit bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd512);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic m_commit(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        m_valid <= 1'b1;
        m_err   <= bad(a);
        m_rdata <= (bad(a) || w) ? 32'd0 : mm[a[8:2]];
        if (!bad(a) && w) mm[a[8:2]] <= merge(mm[a[8:2]], d, s);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_valid <= 1'b0;
            m_rdata <= 32'd0;
            m_err   <= 1'b0;
        end else if (m_valid) begin
            if (resp_ready) begin
                m_valid <= 1'b0;
                m_rdata <= 32'd0;
                m_err   <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_commit(m_addr, m_write, m_wdata, m_wstrb);
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (req_valid) begin
            if (W == 0) begin
                m_commit(req_addr, req_write, req_wdata, req_wstrb);
            end else begin
                m_addr  <= req_addr;
                m_write <= req_write;
                m_wdata <= req_wdata;
                m_wstrb <= req_wstrb;
                m_busy  <= 1'b1;
                m_left  <= W - 1;
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input int stall, output logic [31:0] rd, output logic er,
                        output int lat, output int accw);
        req_addr = a; req_write = w; req_wdata = d; req_wstrb = s;
        req_valid = 1'b1; resp_ready = 1'b0; accw = 0;
        while (!req_ready && accw < 20) begin @(posedge clk); #1; accw++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~a; req_write = !w; req_wdata = ~d; req_wstrb = ~s;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, W);
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_addr = 32'h0; req_write = 1'b1;
                req_wdata = 32'h0; req_wstrb = 4'hF;
            end
            @(posedge clk); #1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, accw;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
        b_req_valid = 0; b_req_addr = 0; b_req_write = 0; b_req_wdata = 0; b_req_wstrb = 0; b_resp_ready = 0;

        fork
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    chk("cyc_req_ready", req_ready, !(m_busy || m_valid));
                    chk("cyc_resp_valid", resp_valid, m_valid);
                    chk("cyc_resp_rdata", resp_rdata, m_rdata);
                    chk("cyc_resp_err", resp_err, m_err);
                end
            end
        join_none

        @(posedge clk); chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);

        xfer(32'h000, 1, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat, accw);
        xfer(32'h010, 1, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, accw);
        chk("st_full_err", er, 0);
        chk("st_full_rdata", rd, 0);
        xfer(32'h010, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("ld_full", rd, 32'hDEADBEEF);
        xfer(32'h010, 1, 32'h11223344, 4'b0101, 0, rd, er, lat, accw);
        xfer(32'h010, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("ld_strobe", rd, 32'hDE22BE44);
        xfer(32'h010, 1, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, accw);
        chk("st_nostrb_err", er, 0);
        xfer(32'h010, 0, 32'h0, 4'h0, 5, rd, er, lat, accw);
        chk("ld_backpressure", rd, 32'hDE22BE44);
        xfer(32'h1FC, 1, 32'h0BADF00D, 4'hF, 0, rd, er, lat, accw);
        chk("st_top_err", er, 0);
        xfer(32'h1FC, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("ld_top", rd, 32'h0BADF00D);
        xfer(32'h013, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("ld_misalign_err", er, 1);
        chk("ld_misalign_rdata", rd, 0);
        xfer(32'h200, 1, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, accw);
        chk("st_range_err", er, 1);
        xfer(32'h80000000, 1, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, accw);
        chk("st_high_err", er, 1);
        xfer(32'h000, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("ld_word0_kept", rd, 32'hA5A5A5A5);

        xfer(32'h020, 1, 32'h12345678, 4'hF, 0, rd, er, lat, accw);
        req_addr = 32'h020; req_write = 1; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk("midop_busy", req_ready, 0);
        rst_n = 1'b0;
        #1 chk("midop_async_ready", req_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(32'h020, 0, 32'h0, 4'h0, 0, rd, er, lat, accw);
        chk("midop_accept_now", accw, 0);
        chk("midop_no_write", rd, 32'h12345678);

        chk("z_ready", b_req_ready, 1);
        b_req_addr = 32'h020; b_req_write = 1; b_req_wdata = 32'hCAFEF00D; b_req_wstrb = 4'hF; b_req_valid = 1;
        @(posedge clk); #1;
        b_req_valid = 0;
        chk("z_st_valid", b_resp_valid, 1);
        chk("z_st_err", b_resp_err, 0);
        b_resp_ready = 1;
        @(posedge clk); #1;
        b_resp_ready = 0;
        chk("z_idle", b_req_ready, 1);
        b_req_write = 0; b_req_valid = 1;
        @(posedge clk); #1;
        b_req_valid = 0;
        chk("z_ld_valid", b_resp_valid, 1);
        chk("z_ld_rdata", b_resp_rdata, 32'hCAFEF00D);
        b_resp_ready = 1;
        @(posedge clk); #1;
        b_resp_ready = 0;
        chk("z_ld_done", b_resp_valid, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
